scu_clk_div6: RTL and testbench



---
 rtl/scu_clk_pkg.sv | 18 +
 rtl/scu_clk_div_ch.sv | 80 ++++++++
 rtl/scu_clk_div6.sv | 58 +++++
 tb/tb_scu_clk_div6.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/scu_clk_pkg.sv
// Shared types and constants for the SCU programmable clock divider.
package scu_clk_pkg;

  localparam int unsigned MIN_DIV   = 2;
  localparam int unsigned CFG_DIV_W = 8;
  localparam int unsigned SEL_W     = 3;

  typedef struct packed {
    logic [CFG_DIV_W-1:0] div;
    logic                 en;
  } pend_cfg_t;

  // Ratios 0 and 1 cannot produce a distinct high and low phase, so they run as 2.
  function automatic logic [CFG_DIV_W-1:0] clamp_div(input logic [CFG_DIV_W-1:0] d);
    return (d < CFG_DIV_W'(MIN_DIV)) ? CFG_DIV_W'(MIN_DIV) : d;
  endfunction

endpackage

// File: rtl/scu_clk_div_ch.sv
// One divider channel: period counter, pending config slot and the output flop.
module scu_clk_div_ch
  import scu_clk_pkg::*;
#(
  parameter int unsigned RST_DIV = 2,
  parameter bit          RST_EN  = 1'b1
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      wr_i,
  input  pend_cfg_t cfg_i,
  output logic      div_clk_o,
  output logic      busy_o
);

  localparam logic [CFG_DIV_W-1:0] RST_N =
    (RST_DIV < MIN_DIV) ? CFG_DIV_W'(MIN_DIV) : CFG_DIV_W'(RST_DIV);

  logic [CFG_DIV_W-1:0] n_q, n_d;
  logic [CFG_DIV_W-1:0] cnt_q, cnt_d;
  logic                 en_q, en_d;
  logic                 busy_q, busy_d;
  logic                 clk_q, clk_d;
  pend_cfg_t            pend_q, pend_d;

  logic                 at_bnd;
  logic [CFG_DIV_W:0]   half;

  always_comb begin
    half   = ({1'b0, n_q} + (CFG_DIV_W+1)'(1)) >> 1;
    at_bnd = (cnt_q == n_q - CFG_DIV_W'(1));
    clk_d  = ({1'b0, cnt_q} < half);

    n_d    = n_q;
    en_d   = en_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    pend_d = pend_q;

    // The output is always low at a boundary, so swapping N/en here cannot glitch.
    if (busy_q && at_bnd) begin
      n_d    = clamp_div(pend_q.div);
      en_d   = pend_q.en;
      cnt_d  = '0;
      busy_d = 1'b0;
    end else if (at_bnd) begin
      if (en_q) cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CFG_DIV_W'(1);
    end

    // wr_i is only raised while not busy, so it never collides with an apply.
    if (wr_i) begin
      pend_d = cfg_i;
      busy_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      n_q    <= RST_N;
      en_q   <= RST_EN;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      clk_q  <= 1'b0;
      pend_q <= '0;
    end else begin
      n_q    <= n_d;
      en_q   <= en_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      clk_q  <= clk_d;
      pend_q <= pend_d;
    end
  end

  assign div_clk_o = clk_q;
  assign busy_o    = busy_q;

endmodule

// File: rtl/scu_clk_div6.sv
// Six-channel SCU clock divider: config select/ready decode around per-channel dividers.
module scu_clk_div6
  import scu_clk_pkg::*;
#(
  parameter int unsigned NUM_CLK = 6,
  parameter int unsigned DIV_W   = CFG_DIV_W,
  parameter int unsigned RST_DIV = 2,
  parameter bit          RST_EN  = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_valid_i,
  output logic               cfg_ready_o,
  input  logic [SEL_W-1:0]   cfg_sel_i,
  input  logic [DIV_W-1:0]   cfg_div_i,
  input  logic               cfg_en_i,
  output logic [NUM_CLK-1:0] div_clk_o,
  output logic [NUM_CLK-1:0] div_busy_o
);

  // Config handshake: a transfer happens on a clk edge with cfg_valid_i && cfg_ready_o.
  // Ready drops only while the selected channel still holds an unapplied config;
  // selects beyond the last channel are always accepted and dropped.
  logic [NUM_CLK-1:0] wr;
  pend_cfg_t          cfg;

  assign cfg.div = CFG_DIV_W'(cfg_div_i);
  assign cfg.en  = cfg_en_i;

  always_comb begin
    cfg_ready_o = 1'b1;
    for (int k = 0; k < NUM_CLK; k++) begin
      if (cfg_sel_i == SEL_W'(k)) cfg_ready_o = !div_busy_o[k];
    end
  end

  always_comb begin
    wr = '0;
    for (int k = 0; k < NUM_CLK; k++) begin
      wr[k] = cfg_valid_i && cfg_ready_o && (cfg_sel_i == SEL_W'(k));
    end
  end

  for (genvar g = 0; g < NUM_CLK; g++) begin : g_ch
    scu_clk_div_ch #(
      .RST_DIV (RST_DIV),
      .RST_EN  (RST_EN)
    ) u_ch (
      .clk       (clk),
      .rst       (rst),
      .wr_i      (wr[g]),
      .cfg_i     (cfg),
      .div_clk_o (div_clk_o[g]),
      .busy_o    (div_busy_o[g])
    );
  end

endmodule

// File: tb/tb_scu_clk_div6.sv
// Directed bench for scu_clk_div6; expected waveforms are hand-derived per cycle.
module tb_scu_clk_div6;

  logic       clk = 1'b0;
  logic       rst;
  logic       cfg_valid_i;
  logic       cfg_ready_o;
  logic [2:0] cfg_sel_i;
  logic [7:0] cfg_div_i;
  logic       cfg_en_i;
  logic [5:0] div_clk_o;
  logic [5:0] div_busy_o;

  int checks   = 0;
  int failures = 0;

  scu_clk_div6 dut (
    .clk         (clk),
    .rst         (rst),
    .cfg_valid_i (cfg_valid_i),
    .cfg_ready_o (cfg_ready_o),
    .cfg_sel_i   (cfg_sel_i),
    .cfg_div_i   (cfg_div_i),
    .cfg_en_i    (cfg_en_i),
    .div_clk_o   (div_clk_o),
    .div_busy_o  (div_busy_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic drive(input logic v, input logic [2:0] s, input logic [7:0] d, input logic e);
    cfg_valid_i = v;
    cfg_sel_i   = s;
    cfg_div_i   = d;
    cfg_en_i    = e;
  endtask

  // Checks one output bit over n cycles; pat is read MSB-first.
  task automatic check_bit_seq(input string tag, input int ch, input int n, input logic [15:0] pat);
    for (int i = 0; i < n; i++) begin
      cyc();
      check(tag, 32'(div_clk_o[ch]), 32'(pat[n-1-i]));
    end
  endtask

  // Asserts reset off-edge, confirms outputs clear asynchronously, releases at a negedge.
  task automatic do_reset();
    #2 rst = 1'b1;
    #1;
    check("async_rst_clk", 32'(div_clk_o), 32'h0);
    check("async_rst_busy", 32'(div_busy_o), 32'h0);
    cyc();
    cyc();
    rst = 1'b0;
  endtask

  initial begin
    logic [1:0] exp_c [8];
    exp_c = '{2'b11, 2'b00, 2'b11, 2'b10, 2'b01, 2'b10, 2'b11, 2'b00};

    rst = 1'b1;
    drive(1'b0, 3'd0, 8'd0, 1'b0);
    cyc();
    cyc();
    check("rst_clk", 32'(div_clk_o), 32'h0);
    check("rst_busy", 32'(div_busy_o), 32'h0);
    check("rst_ready", 32'(cfg_ready_o), 32'h1);
    rst = 1'b0;

    // Reset defaults: N=2 on every channel, high on odd cycles.
    for (int i = 1; i <= 4; i++) begin
      cyc();
      check("dflt_clk", 32'(div_clk_o), (i % 2 == 1) ? 32'h3f : 32'h0);
      check("dflt_busy", 32'(div_busy_o), 32'h0);
    end

    // Ratio change on ch0 to N=5, requested mid-period.
    drive(1'b1, 3'd0, 8'd5, 1'b1);
    #1 check("b_ready", 32'(cfg_ready_o), 32'h1);
    cyc();
    cfg_valid_i = 1'b0;
    #1;
    check("b_busy_set", 32'(div_busy_o), 32'h01);
    check("b_ready_lo", 32'(cfg_ready_o), 32'h0);
    check("b_clk5", 32'(div_clk_o[0]), 32'h1);
    cyc();
    check("b_busy_clr", 32'(div_busy_o), 32'h0);
    check("b_clk6", 32'(div_clk_o[0]), 32'h0);
    check_bit_seq("b_n5", 0, 10, 16'b1110011100);

    // Clamp (div=0 on ch1) and odd ratio 3 on ch2, the latter accepted on a boundary.
    do_reset();
    drive(1'b1, 3'd1, 8'd0, 1'b1);
    #1 check("c_ready1", 32'(cfg_ready_o), 32'h1);
    cyc();
    check("c_busy1", 32'(div_busy_o), 32'h02);
    check("c_clk1", 32'(div_clk_o[2:1]), 32'h3);
    drive(1'b1, 3'd2, 8'd3, 1'b1);
    #1 check("c_ready2", 32'(cfg_ready_o), 32'h1);
    cyc();
    cfg_valid_i = 1'b0;
    check("c_busy2", 32'(div_busy_o), 32'h04);
    check("c_clk2", 32'(div_clk_o[2:1]), 32'h0);
    for (int i = 0; i < 8; i++) begin
      cyc();
      check("c_clk", 32'(div_clk_o[2:1]), 32'(exp_c[i]));
      if (i == 0) check("c_busy3", 32'(div_busy_o), 32'h04);
      if (i == 1) check("c_busy4", 32'(div_busy_o), 32'h0);
    end

    // Disable ch3, then re-enable at N=4 while idle.
    do_reset();
    drive(1'b1, 3'd3, 8'd2, 1'b0);
    #1 check("d_ready", 32'(cfg_ready_o), 32'h1);
    cyc();
    cfg_valid_i = 1'b0;
    check("d_busy", 32'(div_busy_o), 32'h08);
    check("d_clk1", 32'(div_clk_o[3]), 32'h1);
    check_bit_seq("d_off", 3, 5, 16'b01000);
    drive(1'b1, 3'd3, 8'd4, 1'b1);
    #1 check("d_ready_idle", 32'(cfg_ready_o), 32'h1);
    cyc();
    cfg_valid_i = 1'b0;
    check("d_busy_idle", 32'(div_busy_o), 32'h08);
    check("d_clk7", 32'(div_clk_o[3]), 32'h0);
    cyc();
    check("d_busy_clr", 32'(div_busy_o), 32'h0);
    check("d_clk8", 32'(div_clk_o[3]), 32'h0);
    check_bit_seq("d_n4", 3, 6, 16'b110011);

    // Back-pressure on ch4 at N=8, independent ch5 write, discarded sel=7.
    do_reset();
    drive(1'b1, 3'd4, 8'd8, 1'b1);
    #1 check("e_ready0", 32'(cfg_ready_o), 32'h1);
    cyc();
    #1;
    check("e_ready1", 32'(cfg_ready_o), 32'h0);
    check("e_busy1", 32'(div_busy_o), 32'h10);
    cyc();
    #1;
    check("e_ready2", 32'(cfg_ready_o), 32'h1);
    check("e_busy2", 32'(div_busy_o), 32'h0);
    cyc();
    check("e_busy3", 32'(div_busy_o), 32'h10);
    check("e_clk3", 32'(div_clk_o[4]), 32'h1);
    #1 check("e_ready3", 32'(cfg_ready_o), 32'h0);
    drive(1'b1, 3'd5, 8'd2, 1'b1);
    #1 check("e_ready_ch5", 32'(cfg_ready_o), 32'h1);
    cyc();
    check("e_busy4", 32'(div_busy_o), 32'h30);
    check("e_clk4", 32'(div_clk_o[4]), 32'h1);
    drive(1'b1, 3'd7, 8'd9, 1'b0);
    #1 check("e_ready_sel7", 32'(cfg_ready_o), 32'h1);
    cyc();
    check("e_busy5", 32'(div_busy_o), 32'h30);
    check("e_clk5", 32'(div_clk_o[4]), 32'h1);
    drive(1'b1, 3'd4, 8'd3, 1'b1);
    #1 check("e_ready5", 32'(cfg_ready_o), 32'h0);
    cyc();
    #1;
    check("e_busy6", 32'(div_busy_o), 32'h10);
    check("e_ready6", 32'(cfg_ready_o), 32'h0);
    check("e_clk6", 32'(div_clk_o[4]), 32'h1);
    for (int i = 7; i <= 9; i++) begin
      cyc();
      #1;
      check("e_ready_wait", 32'(cfg_ready_o), 32'h0);
      check("e_clk_lo", 32'(div_clk_o[4]), 32'h0);
    end
    cyc();
    #1;
    check("e_busy10", 32'(div_busy_o), 32'h0);
    check("e_ready10", 32'(cfg_ready_o), 32'h1);
    check("e_clk10", 32'(div_clk_o[4]), 32'h0);
    cyc();
    cfg_valid_i = 1'b0;
    check("e_busy11", 32'(div_busy_o), 32'h10);
    check("e_clk11", 32'(div_clk_o[4]), 32'h1);

    // Async reset while ch0 runs N=200 with another config pending.
    do_reset();
    drive(1'b1, 3'd0, 8'd200, 1'b1);
    cyc();
    cfg_valid_i = 1'b0;
    cyc();
    check("f_busy2", 32'(div_busy_o), 32'h0);
    drive(1'b1, 3'd0, 8'd5, 1'b1);
    cyc();
    cfg_valid_i = 1'b0;
    check("f_busy3", 32'(div_busy_o), 32'h01);
    check("f_clk3", 32'(div_clk_o[0]), 32'h1);
    do_reset();
    for (int i = 1; i <= 4; i++) begin
      cyc();
      check("f_n2", 32'(div_clk_o[0]), (i % 2 == 1) ? 32'h1 : 32'h0);
      check("f_busy", 32'(div_busy_o), 32'h0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
